// File: rtl/ysram_pkg.sv
// Shared Y-matrix SRAM bus definitions: geometry, responder state encoding and
// the arbiter's idle write address.
package ysram_pkg;

  localparam int unsigned Y_ADDR_W = 11;
  localparam int unsigned Y_DATA_W = 256;
  localparam int unsigned Y_DEPTH  = 2048;
  localparam int unsigned Y_LANE_W = 64;

  localparam logic [Y_ADDR_W-1:0] Y_IDLE_WADDR = 11'h7FF;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } yState_t;

endpackage

// File: rtl/ysram_array.sv
// Plain 1W2R storage array with registered read-old-data outputs; this is the
// boundary where a compiled SRAM macro gets swapped in.
module ysram_array #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr1,
  input  logic [ADDR_W-1:0] rAddr2,
  output logic [DATA_W-1:0] rData1,
  output logic [DATA_W-1:0] rData2
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers only write in-range rows; out-of-range read data is masked upstream.
  always_ff @(posedge clock) begin
    if (we) mem[IDX_W'(wAddr)] <= wData;
    rData1 <= mem[IDX_W'(rAddr1)];
    rData2 <= mem[IDX_W'(rAddr2)];
  end

endmodule

// File: rtl/ysram_responder.sv
// Y-matrix SRAM responder: zero-fill sweep after reset, then one write and two
// registered reads per cycle with write-first forwarding on collisions.
module ysram_responder
  import ysram_pkg::*;
#(
  parameter int unsigned DEPTH  = Y_DEPTH,
  parameter int unsigned ADDR_W = Y_ADDR_W,
  parameter int unsigned DATA_W = Y_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteBus,
  input  logic [ADDR_W-1:0] ReadAddress1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  output logic [DATA_W-1:0] ReadBus1,
  output logic [DATA_W-1:0] ReadBus2,
  output logic              op_ready,
  output logic              op_wrDropped
);

  yState_t           state, stateNext;
  logic [ADDR_W-1:0] sweepCount, sweepNext;
  logic              sweepLast;

  logic              wrInRange, rd1InRange, rd2InRange;
  logic              wrOk, dropNow;
  logic              hit1, hit2, zero1, zero2;

  logic              arrWe;
  logic [ADDR_W-1:0] arrWAddr;
  logic [DATA_W-1:0] arrWData;
  logic [DATA_W-1:0] arrRData1, arrRData2;

  logic              zero1Q, zero2Q, fwd1Q, fwd2Q;
  logic [DATA_W-1:0] fwdDataQ;

  assign sweepLast  = (sweepCount == ADDR_W'(DEPTH - 1));
  assign wrInRange  = (32'(WriteAddress) < DEPTH);
  assign rd1InRange = (32'(ReadAddress1) < DEPTH);
  assign rd2InRange = (32'(ReadAddress2) < DEPTH);

  // Sweep/write arbitration for the single array write port plus read-source select.
  always_comb begin
    stateNext = state;
    sweepNext = sweepCount;
    arrWe     = 1'b0;
    arrWAddr  = WriteAddress;
    arrWData  = WriteBus;
    wrOk      = 1'b0;
    dropNow   = 1'b0;
    case (state)
      INIT: begin
        arrWe    = 1'b1;
        arrWAddr = sweepCount;
        arrWData = '0;
        dropNow  = WE;
        if (sweepLast) stateNext = READY;
        else           sweepNext = sweepCount + ADDR_W'(1);
      end
      READY: begin
        wrOk    = WE && wrInRange;
        arrWe   = wrOk;
        dropNow = WE && !wrInRange;
      end
      default: stateNext = INIT;
    endcase
    hit1  = wrOk && (ReadAddress1 == WriteAddress);
    hit2  = wrOk && (ReadAddress2 == WriteAddress);
    zero1 = (state != READY) || !rd1InRange;
    zero2 = (state != READY) || !rd2InRange;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= INIT;
      sweepCount   <= '0;
      op_ready     <= 1'b0;
      op_wrDropped <= 1'b0;
      zero1Q       <= 1'b1;
      zero2Q       <= 1'b1;
      fwd1Q        <= 1'b0;
      fwd2Q        <= 1'b0;
    end else begin
      state        <= stateNext;
      sweepCount   <= sweepNext;
      op_ready     <= (stateNext == READY);
      op_wrDropped <= op_wrDropped | dropNow;
      zero1Q       <= zero1;
      zero2Q       <= zero2;
      fwd1Q        <= hit1;
      fwd2Q        <= hit2;
    end
  end

  // Forwarded write data; only observed when a fwd select was set on the same edge.
  always_ff @(posedge clock) begin
    if (wrOk) fwdDataQ <= WriteBus;
  end

  ysram_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clock (clock),
    .we    (arrWe),
    .wAddr (arrWAddr),
    .wData (arrWData),
    .rAddr1(ReadAddress1),
    .rAddr2(ReadAddress2),
    .rData1(arrRData1),
    .rData2(arrRData2)
  );

  // Selects are reset flops, so the buses read zero the moment reset asserts.
  assign ReadBus1 = zero1Q ? '0 : (fwd1Q ? fwdDataQ : arrRData1);
  assign ReadBus2 = zero2Q ? '0 : (fwd2Q ? fwdDataQ : arrRData2);

endmodule

// File: tb/tb_ysram_responder.sv
// Scoreboard bench for ysram_responder: reference model predicts each edge's
// read data, ready and drop flag; a DEPTH=1000 instance covers range drops.
module tb_ysram_responder;

  localparam int unsigned DEPTH_M = 2048;
  localparam int unsigned DEPTH_S = 1000;

  logic         clock = 1'b0;
  logic         reset, reset2;
  logic         we, we2;
  logic [10:0]  wAddr, rAddr1, rAddr2, wAddr2, rAddr1s, rAddr2s;
  logic [255:0] wBus, wBus2;
  logic [255:0] readBus1, readBus2, readBus1s, readBus2s;
  logic         opReady, opDrop, opReady2, opDrop2;

  int checks = 0;
  int errors = 0;

  logic [255:0] mMem [DEPTH_M];
  bit           mReady, mDrop;
  int           mSweep;
  logic [255:0] expQ1 [$];
  logic [255:0] expQ2 [$];

  always #5 clock = ~clock;

  ysram_responder dut (
    .clock(clock), .reset(reset), .WE(we), .WriteAddress(wAddr), .WriteBus(wBus),
    .ReadAddress1(rAddr1), .ReadAddress2(rAddr2), .ReadBus1(readBus1), .ReadBus2(readBus2),
    .op_ready(opReady), .op_wrDropped(opDrop)
  );

  ysram_responder #(.DEPTH(DEPTH_S)) dutSmall (
    .clock(clock), .reset(reset2), .WE(we2), .WriteAddress(wAddr2), .WriteBus(wBus2),
    .ReadAddress1(rAddr1s), .ReadAddress2(rAddr2s), .ReadBus1(readBus1s), .ReadBus2(readBus2s),
    .op_ready(opReady2), .op_wrDropped(opDrop2)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mReady = 1'b0;
    mDrop  = 1'b0;
    mSweep = 0;
    for (int i = 0; i < int'(DEPTH_M); i++) mMem[i] = '0;
    expQ1.delete();
    expQ2.delete();
  endtask

  function automatic logic [255:0] expRead(input logic [10:0] ra, input bit wOk);
    if (!mReady || int'(ra) >= int'(DEPTH_M)) return '0;
    if (wOk && ra == wAddr) return wBus;
    return mMem[ra];
  endfunction

  // One clock edge: predict with current inputs, advance model, then compare.
  task automatic cycle();
    bit wOk;
    wOk = mReady && we && (int'(wAddr) < int'(DEPTH_M));
    expQ1.push_back(expRead(rAddr1, wOk));
    expQ2.push_back(expRead(rAddr2, wOk));
    if (!mReady) begin
      if (we) mDrop = 1'b1;
      mMem[mSweep] = '0;
      if (mSweep == int'(DEPTH_M) - 1) mReady = 1'b1;
      else mSweep++;
    end else if (we) begin
      if (wOk) mMem[wAddr] = wBus;
      else     mDrop = 1'b1;
    end
    @(posedge clock);
    #1;
    chk("rd1", readBus1, expQ1.pop_front());
    chk("rd2", readBus2, expQ2.pop_front());
    chk("ready", 256'(opReady), 256'(mReady));
    chk("drop", 256'(opDrop), 256'(mDrop));
  endtask

  task automatic chkResetState(input string tag);
    chk({tag, "_rd1"}, readBus1, '0);
    chk({tag, "_rd2"}, readBus2, '0);
    chk({tag, "_ready"}, 256'(opReady), '0);
    chk({tag, "_drop"}, 256'(opDrop), '0);
  endtask

  task automatic cycleSmall();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [255:0] patA5, pat1234, patX, patY, patP, patQ;
    int readyAt;
    patA5   = {32{8'hA5}};
    pat1234 = {16{16'h1234}};
    patX    = {8{32'hCAFE_F00D}};
    patY    = {8{32'h0BAD_BEEF}};
    patP    = {4{64'h0123_4567_89AB_CDEF}};
    patQ    = {4{64'hFEDC_BA98_7654_3210}};

    reset = 1'b1; reset2 = 1'b1;
    we = 1'b0; wAddr = '0; wBus = '0; rAddr1 = '0; rAddr2 = '0;
    we2 = 1'b0; wAddr2 = '0; wBus2 = '0; rAddr1s = '0; rAddr2s = '0;
    @(posedge clock);
    #1;
    chkResetState("rst0");
    modelReset();
    reset = 1'b0;

    // Init sweep with a dropped write at cycle 5 and reads of boundary rows.
    for (int i = 1; i <= int'(DEPTH_M); i++) begin
      we     = (i == 5);
      wAddr  = (i == 5) ? 11'd3 : 11'd0;
      wBus   = (i == 5) ? patA5 : '0;
      rAddr1 = 11'($urandom_range(0, 2047));
      rAddr2 = 11'($urandom_range(0, 2047));
      if (i == 100) begin rAddr1 = 11'd0; rAddr2 = 11'd1023; end
      if (i == DEPTH_M) begin rAddr1 = 11'd2047; rAddr2 = 11'd3; end
      cycle();
    end

    // Post-ready: boundary rows and row 3 are zero.
    we = 1'b0; rAddr1 = 11'd3; rAddr2 = 11'd2047; cycle();
    rAddr1 = 11'd0; rAddr2 = 11'd1023; cycle();

    // Write row 10, read it back on port 1.
    we = 1'b1; wAddr = 11'd10; wBus = pat1234; rAddr1 = 11'd0; cycle();
    we = 1'b0; rAddr1 = 11'd10; cycle();

    // Same-edge collision on both ports over an old value.
    we = 1'b1; wAddr = 11'd20; wBus = patY; cycle();
    we = 1'b1; wAddr = 11'd20; wBus = patX; rAddr1 = 11'd20; rAddr2 = 11'd20; cycle();
    we = 1'b0; cycle();

    // Random traffic in a small window to exercise collisions.
    for (int i = 0; i < 300; i++) begin
      we     = 1'($urandom_range(0, 1));
      wAddr  = 11'($urandom_range(0, 15));
      wBus   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rAddr1 = 11'($urandom_range(0, 15));
      rAddr2 = 11'($urandom_range(0, 15));
      cycle();
    end

    // Reset mid-operation while ReadBus1 is showing nonzero data.
    we = 1'b0; rAddr1 = 11'd10; rAddr2 = 11'd20; cycle();
    #3;
    reset = 1'b1;
    #1;
    chkResetState("rstReady");
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Partial sweep with a dropped write, then reset at sweep count 700.
    for (int i = 1; i <= 700; i++) begin
      we     = (i == 100);
      wAddr  = 11'd7;
      wBus   = patA5;
      rAddr1 = 11'($urandom_range(0, 2047));
      rAddr2 = 11'($urandom_range(0, 2047));
      cycle();
    end
    we = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chkResetState("rstSweep");
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= int'(DEPTH_M); i++) begin
      rAddr1 = 11'($urandom_range(0, 2047));
      rAddr2 = 11'($urandom_range(0, 2047));
      cycle();
    end
    rAddr1 = 11'd10; rAddr2 = 11'd20; cycle();

    // DEPTH=1000 instance: ready timing and out-of-range handling.
    reset2 = 1'b0;
    readyAt = 0;
    for (int i = 1; i <= 1100; i++) begin
      cycleSmall();
      if (opReady2 && readyAt == 0) readyAt = i;
    end
    chk("small_readyAt", 256'(readyAt), 256'(DEPTH_S));
    chk("small_drop0", 256'(opDrop2), '0);
    we2 = 1'b1; wAddr2 = 11'd999; wBus2 = patP;
    cycleSmall();
    chk("small_dropAfter999", 256'(opDrop2), '0);
    we2 = 1'b1; wAddr2 = 11'd1500; wBus2 = patQ; rAddr1s = 11'd1500; rAddr2s = 11'd999;
    cycleSmall();
    chk("small_rd1500", readBus1s, '0);
    chk("small_rd999", readBus2s, patP);
    chk("small_drop1500", 256'(opDrop2), 256'(1));
    we2 = 1'b0;
    cycleSmall();
    chk("small_rd1500b", readBus1s, '0);
    chk("small_dropSticky", 256'(opDrop2), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
